// File: rtl/alu_if.sv
// ============================================================================
// Module   : alu_if
// Brief    : Operand/opcode request and registered result bundle for the ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_if #(
  parameter int N = 32
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   ALUControl;
  logic         in_valid;
  logic [N-1:0] Result;
  logic         oVerflow;
  logic         out_valid;

  modport master (
    output A, B, ALUControl, in_valid,
    input  Result, oVerflow, out_valid
  );

  modport slave (
    input  A, B, ALUControl, in_valid,
    output Result, oVerflow, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : N-bit ADD/SUB/AND/XOR/SLT unit with one-cycle registered result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu #(
  parameter int N = 32
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic         add_ovf;
  logic         sub_ovf;
  logic         slt;
  logic [N-1:0] alu_res;
  logic         alu_ovf;

  logic [N-1:0] result_d, result_q;
  logic         ovf_d, ovf_q;
  logic         valid_d, valid_q;

  assign sum  = bus.A + bus.B;
  assign diff = bus.A - bus.B;

  assign add_ovf = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1]  != bus.A[N-1]);
  assign sub_ovf = (bus.A[N-1] != bus.B[N-1]) && (diff[N-1] != bus.A[N-1]);

  // Difference sign is wrong exactly when the subtraction overflowed.
  assign slt = diff[N-1] ^ sub_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUControl)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      OP_AND:  alu_res = bus.A & bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SLT:  alu_res = {{(N-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (bus.in_valid) begin
      result_d = alu_res;
      ovf_d    = alu_ovf;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.Result    = result_q;
  assign bus.oVerflow  = ovf_q;
  assign bus.out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Brief    : Scoreboard-driven testbench for the alu block (N = 32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu;

  typedef struct {
    logic [31:0] res;
    logic        ov;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  alu_if #(.N(32)) bus ();

  alu #(.N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  // Reference model computed with 64-bit signed arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint s;
    r  = '0;
    ov = 1'b0;
    case (op)
      3'b000: begin s = sa + sbv; r = s[31:0]; ov = (s != longint'($signed(r))); end
      3'b001: begin s = sa - sbv; r = s[31:0]; ov = (s != longint'($signed(r))); end
      3'b010: r = a & b;
      3'b011: r = a ^ b;
      3'b101: r = (sa < sbv) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    bus.in_valid   = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'b000, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.Result !== 32'd0 || bus.oVerflow !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: got res=%h ov=%b vld=%b, expected res=0 ov=0 vld=0",
               bus.Result, bus.oVerflow, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] va[4] = '{32'd10, 32'd10, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vb[4] = '{32'd5, 32'hFFFFFFFB, 32'd1, 32'h80000000};
    logic [31:0] vr[4] = '{32'd15, 32'd5, 32'h80000000, 32'd0};
    logic        vo[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_t e;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Result !== e.res || bus.oVerflow !== e.ov) begin
          errors++;
          $display("FAIL add[%0d]: got vld=%b res=%h ov=%b, expected vld=1 res=%h ov=%b",
                   i-1, bus.out_valid, bus.Result, bus.oVerflow, e.res, e.ov);
        end
      end
      if (i < 4) begin
        drive(3'b000, va[i], vb[i]);
        sb.push_back('{vr[i], vo[i]});
      end else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_sub();
    logic [31:0] va[4] = '{32'd5, 32'hFFFFFFF6, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vb[4] = '{32'd10, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd1};
    logic [31:0] vr[4] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF};
    logic        vo[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_t e;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Result !== e.res || bus.oVerflow !== e.ov) begin
          errors++;
          $display("FAIL sub[%0d]: got vld=%b res=%h ov=%b, expected vld=1 res=%h ov=%b",
                   i-1, bus.out_valid, bus.Result, bus.oVerflow, e.res, e.ov);
        end
      end
      if (i < 4) begin
        drive(3'b001, va[i], vb[i]);
        sb.push_back('{vr[i], vo[i]});
      end else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_logic();
    logic [2:0]  vop[4] = '{3'b010, 3'b011, 3'b011, 3'b010};
    logic [31:0] va[4]  = '{32'hABCDEF01, 32'hF0F0F0F0, 32'd10, 32'h7FFFFFFF};
    logic [31:0] vb[4]  = '{32'hFFFFFFFF, 32'h0F0F0F0F, 32'd10, 32'h7FFFFFFF};
    logic [31:0] vr[4]  = '{32'hABCDEF01, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF};
    exp_t e;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Result !== e.res || bus.oVerflow !== e.ov) begin
          errors++;
          $display("FAIL logic[%0d]: got vld=%b res=%h ov=%b, expected vld=1 res=%h ov=%b",
                   i-1, bus.out_valid, bus.Result, bus.oVerflow, e.res, e.ov);
        end
      end
      if (i < 4) begin
        drive(vop[i], va[i], vb[i]);
        sb.push_back('{vr[i], 1'b0});
      end else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_slt();
    logic [31:0] va[7] = '{32'd5, 32'hFFFFFFFB, 32'd5, 32'hFFFFFFF6, 32'd10,
                           32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vb[7] = '{32'd10, 32'd10, 32'hFFFFFFF6, 32'hFFFFFFFB, 32'd10,
                           32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vr[7] = '{32'd1, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    exp_t e;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Result !== e.res || bus.oVerflow !== e.ov) begin
          errors++;
          $display("FAIL slt[%0d]: got vld=%b res=%h ov=%b, expected vld=1 res=%h ov=%b",
                   i-1, bus.out_valid, bus.Result, bus.oVerflow, e.res, e.ov);
        end
      end
      if (i < 7) begin
        drive(3'b101, va[i], vb[i]);
        sb.push_back('{vr[i], 1'b0});
      end else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_undefined();
    logic [2:0] vop[3] = '{3'b100, 3'b110, 3'b111};
    exp_t e;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Result !== e.res || bus.oVerflow !== e.ov) begin
          errors++;
          $display("FAIL undef[%0d]: got vld=%b res=%h ov=%b, expected vld=1 res=%h ov=%b",
                   i-1, bus.out_valid, bus.Result, bus.oVerflow, e.res, e.ov);
        end
      end
      if (i < 3) begin
        drive(vop[i], 32'h7FFFFFFF, 32'd1);
        sb.push_back('{32'd0, 1'b0});
      end else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
    logic [31:0] a, b, r;
    logic [2:0]  op;
    logic        ov;
    exp_t e;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Result !== e.res || bus.oVerflow !== e.ov) begin
          errors++;
          $display("FAIL b2b[%0d]: got vld=%b res=%h ov=%b, expected vld=1 res=%h ov=%b",
                   i-1, bus.out_valid, bus.Result, bus.oVerflow, e.res, e.ov);
        end
      end
      if (i < 60) begin
        op = 3'($urandom_range(7));
        a  = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
        b  = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
        model(op, a, b, r, ov);
        drive(op, a, b);
        sb.push_back('{r, ov});
      end else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    drive(3'b000, 32'd1, 32'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Result !== 32'd3) begin
      errors++;
      $display("FAIL hold_load: got vld=%b res=%h, expected vld=1 res=00000003", bus.out_valid, bus.Result);
    end
    for (int i = 0; i < 3; i++) begin
      bus.A = $urandom;
      bus.B = $urandom;
      bus.ALUControl = 3'b001;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.Result !== 32'd3 || bus.oVerflow !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got vld=%b res=%h ov=%b, expected vld=0 res=00000003 ov=0",
                 i, bus.out_valid, bus.Result, bus.oVerflow);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    drive(3'b001, 32'd100, 32'd1);
    #4;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Result !== 32'd3) begin
      errors++;
      $display("FAIL latency_early: got vld=%b res=%h, expected vld=0 res=00000003", bus.out_valid, bus.Result);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.Result !== 32'd99 || bus.oVerflow !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge: got vld=%b res=%h ov=%b, expected vld=1 res=00000063 ov=0",
               bus.out_valid, bus.Result, bus.oVerflow);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(3'b000, 32'h7FFFFFFF, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.Result !== 32'd0 || bus.oVerflow !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got res=%h ov=%b vld=%b, expected res=0 ov=0 vld=0",
               bus.Result, bus.oVerflow, bus.out_valid);
    end
    drive(3'b000, 32'd20, 32'd22);
    @(posedge clk);
    #1;
    checks++;
    if (bus.Result !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got res=%h vld=%b, expected res=0 vld=0", bus.Result, bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.Result !== 32'd42 || bus.oVerflow !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got res=%h ov=%b vld=%b, expected res=0000002a ov=0 vld=1",
               bus.Result, bus.oVerflow, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.ALUControl = 3'b000;
    bus.in_valid = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_slt();
    test_undefined();
    test_back_to_back();
    test_hold();
    test_latency();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter N, default 32, operand and result width in bits; the block SHALL support any N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 A  input  N  operand A, two's complement when signed.
REQ-005 B  input  N  operand B, two's complement when signed.
REQ-006 ALUControl  input  3  operation select.
REQ-007 in_valid  input  1  high when A/B/ALUControl hold an operation to be captured this cycle.
REQ-008 Result  output  N  registered operation result.
REQ-009 oVerflow  output  1  registered signed-overflow flag for the operation in Result.
REQ-010 out_valid  output  1  high for exactly the cycle(s) Result/oVerflow hold a newly computed operation.

Function
REQ-011 Opcode map SHALL be: 000 ADD (A+B); 001 SUB (A-B); 010 AND (A&B); 011 XOR (A^B); 101 SLT (signed A<B); 100, 110 and 111 undefined.
REQ-012 ADD/SUB SHALL be modulo 2^N; the carry/borrow out is discarded.
REQ-013 ADD overflow SHALL be 1 iff A and B have equal sign bits and the sum's sign differs from A's sign.
REQ-014 SUB overflow SHALL be 1 iff A and B have different sign bits and the difference's sign differs from A's sign.
REQ-015 SLT SHALL set Result to N-1 zeros followed by LSB = 1 when A < B as signed integers, else all zeros.
REQ-016 SLT SHALL compare correctly across the full range, including when A-B overflows (use the difference sign XOR subtraction overflow).
REQ-017 AND, XOR and SLT SHALL drive oVerflow = 0.
REQ-018 Undefined opcodes SHALL produce Result = 0 and oVerflow = 0; no X propagation.
REQ-019 Computation SHALL be combinational from A/B/ALUControl; Result, oVerflow and out_valid SHALL be registered, giving a latency of exactly one clock.
REQ-020 On a rising edge with in_valid = 1, the block SHALL load Result and oVerflow with the computed values and set out_valid = 1.
REQ-021 On a rising edge with in_valid = 0, the block SHALL hold Result and oVerflow and set out_valid = 0.
REQ-022 Back-to-back operations (in_valid high every cycle) SHALL be accepted at one per clock with no stalls.
REQ-023 Changes to inputs between clock edges SHALL have no effect on outputs until the next qualifying edge.

Reset
REQ-024 While rst = 1, Result, oVerflow and out_valid SHALL be 0 immediately, independent of clk.
REQ-025 Reset asserted mid-stream SHALL discard the pending operation; the first capture after deassertion occurs on the first rising edge with rst = 0 and in_valid = 1.

Verification
REQ-026 ADD:
- 10+5 -> 15, ov 0.
- 10+0xFFFFFFFB -> 5, ov 0.
- 0x7FFFFFFF+1 -> 0x80000000, ov 1.
- 0x80000000+0x80000000 -> 0, ov 1.
REQ-027 SUB:
- 5-10 -> 0xFFFFFFFB, ov 0.
- 0xFFFFFFF6-0xFFFFFFFB -> 0xFFFFFFFB, ov 0.
- 0x7FFFFFFF-0xFFFFFFFF -> 0x80000000, ov 1.
- 0x80000000-1 -> 0x7FFFFFFF, ov 1.
REQ-028 AND/XOR:
- 0xABCDEF01 AND 0xFFFFFFFF -> 0xABCDEF01.
- 0xF0F0F0F0 XOR 0x0F0F0F0F -> 0xFFFFFFFF.
- 10 XOR 10 -> 0.
- ov 0 in all cases.
REQ-029 SLT:
- 5<10 -> 1.
- 0xFFFFFFFB<10 -> 1.
- 5<0xFFFFFFF6 -> 0.
- 0xFFFFFFF6<0xFFFFFFFB -> 1.
- 10<10 -> 0.
- 0x80000000<0x7FFFFFFF -> 1.
- 0x7FFFFFFF<0x80000000 -> 0.
REQ-030 Opcodes 100/110/111 with A=0x7FFFFFFF, B=1 -> Result 0, ov 0, out_valid 1.
REQ-031 Timing and reset:
- Apply an op at edge k -> outputs valid after edge k, not before.
- in_valid low -> outputs hold, out_valid 0.
- rst pulsed between edges -> all outputs 0 at once, with no clock edge needed.
